// File: rtl/instruction_queue.sv
// Circular instruction FIFO that expands each entry into up to three issue lanes
// per cycle, with per-copy address strides and sticky overflow/count error flags.
module instruction_queue #(
  parameter int unsigned LOG_SUPERSCALAR_WIDTH = 3,
  parameter int unsigned LOG_DEPTH             = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             push_we,
  input  logic [1:0]                       push_instr_type,
  input  logic [LOG_SUPERSCALAR_WIDTH:0]   push_copy_count,
  input  logic [8:0]                       push_arith_instr,
  input  logic [2:0]                       push_ram_instr,
  input  logic [6:0]                       push_ld_st_instr,
  input  logic [17:0]                      push_cache_addr,
  input  logic [17:0]                      push_main_mem_addr,
  input  logic [17:0]                      push_d_cache_addr,
  input  logic [17:0]                      push_d_main_mem_addr,
  output logic                             stall_push,
  input  logic                             issue_ready,
  output logic [2:0]                       issue_valid,
  output logic [1:0]                       issue_instr_type,
  output logic [8:0]                       issue_arith_instr,
  output logic [2:0]                       issue_ram_instr,
  output logic [6:0]                       issue_ld_st_instr,
  output logic [3*18-1:0]                  issue_cache_addr,
  output logic [3*18-1:0]                  issue_main_mem_addr,
  output logic                             empty,
  output logic                             overflow_error,
  output logic                             count_error
);

  localparam int unsigned DEPTH = 1 << LOG_DEPTH;
  localparam int unsigned CW    = LOG_SUPERSCALAR_WIDTH + 1;
  localparam int unsigned CNTW  = LOG_DEPTH + 1;
  localparam int unsigned AW    = 18;
  localparam int unsigned LANES = 3;

  typedef struct packed {
    logic [1:0]    itype;
    logic [CW-1:0] copies;
    logic [8:0]    arith;
    logic [2:0]    ram;
    logic [6:0]    ld_st;
    logic [AW-1:0] cache;
    logic [AW-1:0] main_mem;
    logic [AW-1:0] d_cache;
    logic [AW-1:0] d_main_mem;
  } entry_t;

  entry_t               r_mem [DEPTH];
  logic [LOG_DEPTH-1:0] r_rd_ptr;
  logic [LOG_DEPTH-1:0] r_wr_ptr;
  logic [CNTW-1:0]      r_count;
  logic [CW-1:0]        r_off;
  logic                 r_overflow_error;
  logic                 r_count_error;

  entry_t        w_head;
  entry_t        w_new;
  logic          w_empty;
  logic          w_full;
  logic [CW-1:0] w_rem;
  logic          w_zero;
  logic [2:0]    w_valid;
  logic          w_fire;
  logic          w_pop;
  logic          w_push;

  assign w_head  = r_mem[r_rd_ptr];
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNTW'(DEPTH));
  assign w_rem   = w_head.copies - r_off;
  assign w_zero  = !w_empty && (w_head.copies == '0);

  // Lane mask: contiguous from lane 0, never spanning two entries.
  always_comb begin
    w_valid = 3'b000;
    if (!w_empty && (w_rem != '0)) begin
      if (w_rem >= CW'(LANES))   w_valid = 3'b111;
      else if (w_rem == CW'(2))  w_valid = 3'b011;
      else                       w_valid = 3'b001;
    end
  end

  assign w_fire = issue_ready && (w_valid != 3'b000);
  // A zero-copy head is discarded unconditionally so it cannot block the queue.
  assign w_pop  = (w_fire && (w_rem <= CW'(LANES))) || w_zero;
  assign w_push = push_we && (!w_full || w_pop);

  assign w_new = '{
    itype:      push_instr_type,
    copies:     push_copy_count,
    arith:      push_arith_instr,
    ram:        push_ram_instr,
    ld_st:      push_ld_st_instr,
    cache:      push_cache_addr,
    main_mem:   push_main_mem_addr,
    d_cache:    push_d_cache_addr,
    d_main_mem: push_d_main_mem_addr
  };

  // Entry payload storage; no reset needed since count gates visibility.
  always_ff @(posedge clk) begin
    if (!reset && w_push) r_mem[r_wr_ptr] <= w_new;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr         <= '0;
      r_wr_ptr         <= '0;
      r_count          <= '0;
      r_off            <= '0;
      r_overflow_error <= 1'b0;
      r_count_error    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + LOG_DEPTH'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + LOG_DEPTH'(1);
        r_off    <= '0;
      end else if (w_fire) begin
        r_off <= r_off + CW'(LANES);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
      if (push_we && w_full && !w_pop) r_overflow_error <= 1'b1;
      if (w_zero)                      r_count_error    <= 1'b1;
    end
  end

  // Per-lane addresses: base + (off + lane) * stride, wrapping at 18 bits.
  for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
    logic [AW-1:0] w_idx;
    assign w_idx = AW'(r_off) + AW'(i);
    assign issue_cache_addr[i*AW +: AW]    = w_head.cache    + AW'(w_idx * w_head.d_cache);
    assign issue_main_mem_addr[i*AW +: AW] = w_head.main_mem + AW'(w_idx * w_head.d_main_mem);
  end

  assign issue_valid       = w_valid;
  assign issue_instr_type  = w_head.itype;
  assign issue_arith_instr = w_head.arith;
  assign issue_ram_instr   = w_head.ram;
  assign issue_ld_st_instr = w_head.ld_st;
  assign stall_push        = (r_count >= CNTW'(DEPTH - 1));
  assign empty             = w_empty;
  assign overflow_error    = r_overflow_error;
  assign count_error       = r_count_error;

endmodule
